// File: rtl/asteroid_pkg.sv
// Shared types and constants for the asteroid lane engine: the FSM state
// encoding, lane identifiers, the difficulty-to-step multiplier and the
// lane-randomiser LFSR constants.
package asteroid_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HIT  = 2'd2,
        DONE = 2'd3
    } state_e;

    localparam logic LANE_A = 1'b0;
    localparam logic LANE_B = 1'b1;

    // Galois LFSR for x^16+x^14+x^13+x^11+1, right-shifting form.
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    // Base ticks per asteroid step: 8, 6, 4, 2 for difficulty 0..3.
    function automatic logic [3:0] diff_mult(input logic [1:0] d);
        return 4'd8 - {1'b0, d, 1'b0};
    endfunction

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
    endfunction

endpackage

// File: rtl/asteroid_lane_engine_if.sv
// Bundle between the access/game controller and the asteroid lane engine.
// The controller (master) drives the control inputs; the engine (slave)
// returns status pulses, the two LED rows, the dodge count and its state.
//
// Signalling: there is no valid/ready handshake on this bus. NewGamePulse,
// DodgeBtn, CrashDetected and LEDTimeOut are single-cycle pulses that are
// acted on in the cycle they are high; EnableGameElements and Difficulty are
// levels sampled on every clock edge.
interface asteroid_lane_engine_if
    import asteroid_pkg::*;
#(
    parameter int N_LEDS = 10
);
    logic              NewGamePulse;
    logic              EnableGameElements;
    logic [1:0]        Difficulty;
    logic              DodgeBtn;
    logic              CrashDetected;
    logic              LEDTimeOut;
    logic [N_LEDS-1:0] LaneALeds;
    logic [N_LEDS-1:0] LaneBLeds;
    logic [7:0]        DodgeCount;
    state_e            dbg_state;

    modport master (
        output NewGamePulse, EnableGameElements, Difficulty, DodgeBtn,
        input  CrashDetected, LEDTimeOut, LaneALeds, LaneBLeds, DodgeCount,
        input  dbg_state
    );

    modport slave (
        input  NewGamePulse, EnableGameElements, Difficulty, DodgeBtn,
        output CrashDetected, LEDTimeOut, LaneALeds, LaneBLeds, DodgeCount,
        output dbg_state
    );

endinterface

// File: rtl/asteroid_step_timer.sv
// Step-strobe generator. The step length (TICK_DIV * multiplier) is latched
// from Difficulty on restart so a mid-flight change waits for the next spawn.
// The strobe fires on the last cycle of each step and the counter wraps.
module asteroid_step_timer
    import asteroid_pkg::*;
#(
    parameter int TICK_DIV = 5000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       run,
    input  logic       restart,
    input  logic [1:0] difficulty,
    output logic       strobe
);
    localparam int CW = $clog2(TICK_DIV * 8);

    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] term_q, term_d;
    logic [CW-1:0] term_new;

    assign strobe = run && (cnt_q == term_q);

    // Next counter value and latched terminal count.
    always_comb begin
        term_new = CW'(TICK_DIV * int'(diff_mult(difficulty)) - 1);
        cnt_d    = cnt_q;
        term_d   = term_q;
        if (restart) begin
            cnt_d  = '0;
            term_d = term_new;
        end else if (run) begin
            cnt_d = strobe ? '0 : cnt_q + CW'(1);
        end else begin
            cnt_d = '0;
        end
    end

    // Counter and period registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            term_q <= CW'(TICK_DIV * 8 - 1);
        end else begin
            cnt_q  <= cnt_d;
            term_q <= term_d;
        end
    end

endmodule

// File: rtl/asteroid_lane_engine.sv
// Asteroid lane engine: one asteroid at a time walks down a two-lane LED
// track toward the player at index 0. Reports a crash or a survived round
// back to the game controller as registered one-cycle pulses.
// Build option: ASTEROID_RANDOM_LANE_EN picks the spawn lane from a 16-bit
// LFSR; without it spawn lanes alternate A, B, A, ...
module asteroid_lane_engine
    import asteroid_pkg::*;
#(
    parameter int N_LEDS           = 10,
    parameter int TICK_DIV         = 5000000,
    parameter int DODGES_PER_ROUND = 8
) (
    input logic                   Clk,
    input logic                   Reset,
    asteroid_lane_engine_if.slave bus
);
    localparam int              PW          = $clog2(N_LEDS);
    localparam logic [PW-1:0]   POS_START   = PW'(N_LEDS - 1);
    localparam logic [7:0]      DODGE_LIMIT = 8'(DODGES_PER_ROUND);

    state_e            state_q, state_d;
    logic [PW-1:0]     pos_q, pos_d;
    logic              ast_lane_q, ast_lane_d;
    logic              player_lane_q, player_lane_d;
    logic [7:0]        dodge_cnt_q, dodge_cnt_d;
    logic [7:0]        dodge_next;
    logic              crash_q, crash_d;
    logic              timeout_q, timeout_d;
    logic              spawn;
    logic              step;
    logic              lane_pick;
    logic [N_LEDS-1:0] lane_a, lane_b;

    asteroid_step_timer #(
        .TICK_DIV (TICK_DIV)
    ) u_timer (
        .clk        (Clk),
        .rst_n      (Reset),
        .run        (state_q == RUN),
        .restart    (spawn),
        .difficulty (bus.Difficulty),
        .strobe     (step)
    );

`ifdef ASTEROID_RANDOM_LANE_EN
    logic [15:0] lfsr_q, lfsr_d;

    assign lane_pick = lfsr_q[0];

    // Free-running lane randomiser, reseeded by a new game.
    always_comb begin
        lfsr_d = bus.NewGamePulse ? LFSR_SEED : lfsr_next(lfsr_q);
    end

    // LFSR register.
    always_ff @(posedge Clk) begin
        if (!Reset) lfsr_q <= LFSR_SEED;
        else        lfsr_q <= lfsr_d;
    end
`else
    logic alt_lane_q, alt_lane_d;

    assign lane_pick = alt_lane_q;

    // Alternating spawn lane, restarting at A for a new game.
    always_comb begin
        alt_lane_d = alt_lane_q;
        if (bus.NewGamePulse) alt_lane_d = LANE_A;
        else if (spawn)       alt_lane_d = ~alt_lane_q;
    end

    // Alternator register.
    always_ff @(posedge Clk) begin
        if (!Reset) alt_lane_q <= LANE_A;
        else        alt_lane_q <= alt_lane_d;
    end
`endif

    // Game FSM: state transitions, asteroid motion, resolve and pulses.
    always_comb begin
        state_d       = state_q;
        pos_d         = pos_q;
        ast_lane_d    = ast_lane_q;
        player_lane_d = player_lane_q;
        dodge_cnt_d   = dodge_cnt_q;
        dodge_next    = dodge_cnt_q;
        crash_d       = 1'b0;
        timeout_d     = 1'b0;
        spawn         = 1'b0;

        if (bus.NewGamePulse) begin
            // A new game overrides any step or resolve in the same cycle.
            state_d       = IDLE;
            pos_d         = POS_START;
            ast_lane_d    = LANE_A;
            player_lane_d = LANE_A;
            dodge_cnt_d   = '0;
        end else begin
            // The toggle lands before a same-cycle resolve compares lanes.
            if (state_q != HIT && bus.DodgeBtn) player_lane_d = ~player_lane_q;

            unique case (state_q)
                IDLE: begin
                    if (bus.EnableGameElements) begin
                        state_d = RUN;
                        spawn   = 1'b1;
                        // Coming back from a finished round starts a fresh one.
                        if (dodge_cnt_q >= DODGE_LIMIT) dodge_cnt_d = '0;
                    end
                end
                RUN: begin
                    if (!bus.EnableGameElements) begin
                        state_d = IDLE;
                        pos_d   = POS_START;
                    end else if (step) begin
                        if (pos_q != '0) begin
                            pos_d = pos_q - PW'(1);
                        end else if (ast_lane_q == player_lane_d) begin
                            crash_d = 1'b1;
                            state_d = HIT;
                        end else begin
                            if (dodge_cnt_q < DODGE_LIMIT) dodge_next = dodge_cnt_q + 8'd1;
                            dodge_cnt_d = dodge_next;
                            if (dodge_next == DODGE_LIMIT) begin
                                timeout_d = 1'b1;
                                state_d   = DONE;
                            end else begin
                                spawn = 1'b1;
                            end
                        end
                    end
                end
                HIT: begin
                    if (!bus.EnableGameElements) begin
                        state_d = IDLE;
                        pos_d   = POS_START;
                    end
                end
                DONE: begin
                    if (!bus.EnableGameElements) begin
                        state_d = IDLE;
                        pos_d   = POS_START;
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        if (spawn) begin
            pos_d      = POS_START;
            ast_lane_d = lane_pick;
        end
    end

    // FSM and datapath registers.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state_q       <= IDLE;
            pos_q         <= POS_START;
            ast_lane_q    <= LANE_A;
            player_lane_q <= LANE_A;
            dodge_cnt_q   <= '0;
            crash_q       <= 1'b0;
            timeout_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            pos_q         <= pos_d;
            ast_lane_q    <= ast_lane_d;
            player_lane_q <= player_lane_d;
            dodge_cnt_q   <= dodge_cnt_d;
            crash_q       <= crash_d;
            timeout_q     <= timeout_d;
        end
    end

    // LED rows: asteroid at pos in its lane, player at bit 0, dark when idle.
    always_comb begin
        lane_a = '0;
        lane_b = '0;
        if (state_q == RUN || state_q == HIT) begin
            if (ast_lane_q == LANE_A) lane_a[pos_q] = 1'b1;
            else                      lane_b[pos_q] = 1'b1;
            if (player_lane_q == LANE_A) lane_a[0] = 1'b1;
            else                         lane_b[0] = 1'b1;
        end
    end

    assign bus.CrashDetected = crash_q;
    assign bus.LEDTimeOut    = timeout_q;
    assign bus.LaneALeds     = lane_a;
    assign bus.LaneBLeds     = lane_b;
    assign bus.DodgeCount    = dodge_cnt_q;
    assign bus.dbg_state     = state_q;

endmodule
